// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: shared state encoding and mode/direction constants
// for the triangle sweep sequencer.
package updown_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        DWELL_HI  = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_core.sv
// updown_count_core: WIDTH-bit up/down counter; load has priority over en,
// up_down=1 counts down.
module updown_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= up_down ? count - WIDTH'(1) : count + WIDTH'(1);
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives an up/down counter through lo->hi->lo triangle
// sweeps with a dwell at hi, in one-shot or continuous mode.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               at_hi,
    output logic               at_lo,
    output logic               done,
    output logic               err
);

    state_t               state, state_n;
    logic [WIDTH-1:0]     lo_q, hi_q;
    logic [DWELL_W-1:0]   dwell_q, dwell_cnt, dwell_cnt_n;
    logic                 mode_q;
    logic                 dir_n, at_hi_n, at_lo_n, done_n, err_n;
    logic                 load, en, up_down;
    logic                 eq, hit;

    assign eq   = (lo_q == hi_q);
    assign busy = (state != IDLE);
    // After a bottom turnaround the first value shown is lo+1 (or lo itself
    // when lo==hi); if that value is already hi, go straight to the dwell.
    assign hit  = eq || (lo_q + WIDTH'(1) == hi_q);

    updown_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (lo),
        .up_down  (up_down),
        .count    (count)
    );

    always_comb begin
        state_n     = state;
        dir_n       = dir;
        at_hi_n     = 1'b0;
        at_lo_n     = 1'b0;
        done_n      = 1'b0;
        err_n       = err;
        dwell_cnt_n = dwell_cnt;
        load        = 1'b0;
        en          = 1'b0;
        up_down     = DIR_UP;
        if (state == IDLE) begin
            if (start && !stop) begin
                if (lo > hi) begin
                    err_n = 1'b1;
                end else begin
                    load        = 1'b1;
                    err_n       = 1'b0;
                    dir_n       = DIR_UP;
                    state_n     = (lo == hi) ? DWELL_HI : RAMP_UP;
                    at_hi_n     = (lo == hi);
                    dwell_cnt_n = dwell;
                end
            end
        end else if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                RAMP_UP: begin
                    en = 1'b1;
                    if (count == hi_q - WIDTH'(1)) begin
                        state_n     = DWELL_HI;
                        at_hi_n     = 1'b1;
                        dwell_cnt_n = dwell_q;
                    end
                end
                DWELL_HI: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt_n = dwell_cnt - DWELL_W'(1);
                    end else begin
                        // lo==hi holds the count for one extra bottom-turnaround cycle
                        state_n = RAMP_DOWN;
                        dir_n   = DIR_DOWN;
                        en      = !eq;
                        up_down = DIR_DOWN;
                        at_lo_n = eq || (count - WIDTH'(1) == lo_q);
                        done_n  = at_lo_n && (mode_q == MODE_ONESHOT);
                    end
                end
                RAMP_DOWN: begin
                    if (count != lo_q) begin
                        en      = 1'b1;
                        up_down = DIR_DOWN;
                        at_lo_n = (count - WIDTH'(1) == lo_q);
                        done_n  = at_lo_n && (mode_q == MODE_ONESHOT);
                    end else if (mode_q == MODE_ONESHOT) begin
                        state_n = IDLE;
                    end else begin
                        en          = !eq;
                        dir_n       = DIR_UP;
                        state_n     = hit ? DWELL_HI : RAMP_UP;
                        at_hi_n     = hit;
                        dwell_cnt_n = dwell_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            dwell_cnt <= '0;
            dir       <= DIR_UP;
            at_hi     <= 1'b0;
            at_lo     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_cnt_n;
            dir       <= dir_n;
            at_hi     <= at_hi_n;
            at_lo     <= at_lo_n;
            done      <= done_n;
            err       <= err_n;
            if (load) begin
                lo_q    <= lo;
                hi_q    <= hi;
                dwell_q <= dwell;
                mode_q  <= mode;
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed plus random stimulus against a list-based
// model of one sweep pass.
module tb_updown_sweep_ctrl;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset, start, stop, mode;
    logic [W-1:0] lo, hi;
    logic [D-1:0] dwell;
    logic [W-1:0] count;
    logic         dir, busy, at_hi, at_lo, done, err;

    updown_sweep_ctrl #(.WIDTH(W), .DWELL_W(D)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .lo    (lo),
        .hi    (hi),
        .dwell (dwell),
        .count (count),
        .dir   (dir),
        .busy  (busy),
        .at_hi (at_hi),
        .at_lo (at_lo),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit d;
        bit ah;
        bit al;
    } ent_t;

    ent_t pass_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   idx;
    bit   m_busy, m_mode, m_err, m_eq, m_dir, m_ah, m_al, m_done;
    int   m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One pass: ramp lo..hi, dwell extra cycles at hi, ramp down to lo.
    function automatic void build(input int l, input int h, input int dw);
        pass_q.delete();
        for (int v = l; v <= h; v++) pass_q.push_back('{v, 1'b0, v == h, 1'b0});
        for (int k = 0; k < dw; k++) pass_q.push_back('{h, 1'b0, 1'b0, 1'b0});
        if (l == h) pass_q.push_back('{h, 1'b1, 1'b0, 1'b1});
        else for (int v = h - 1; v >= l; v--) pass_q.push_back('{v, 1'b1, 1'b0, v == l});
    endfunction

    function automatic void emit();
        m_count = pass_q[idx].c;
        m_dir   = pass_q[idx].d;
        m_ah    = pass_q[idx].ah;
        m_al    = pass_q[idx].al;
        m_done  = pass_q[idx].al && !m_mode;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_err = 0; m_count = 0; m_dir = 0; m_ah = 0; m_al = 0; m_done = 0;
    endfunction

    task automatic check_all();
        chk("count", 32'(count), 32'(m_count));
        chk("dir",   32'(dir),   32'(m_dir));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("at_hi", 32'(at_hi), 32'(m_ah));
        chk("at_lo", 32'(at_lo), 32'(m_al));
        chk("done",  32'(done),  32'(m_done));
        chk("err",   32'(err),   32'(m_err));
    endtask

    task automatic cyc(input bit s, input bit sp, input bit md, input int l, input int h, input int dw);
        start = s; stop = sp; mode = md;
        lo = W'(l); hi = W'(h); dwell = D'(dw);
        @(posedge clk);
        m_ah = 0; m_al = 0; m_done = 0;
        if (!m_busy) begin
            if (s && !sp) begin
                if (l > h) m_err = 1;
                else begin
                    build(l, h, dw);
                    m_mode = md; m_eq = (l == h); idx = 0; m_busy = 1; m_err = 0;
                    emit();
                end
            end
        end else if (sp) begin
            m_busy = 0;
        end else begin
            idx++;
            if (idx == pass_q.size()) begin
                if (!m_mode) m_busy = 0;
                else begin
                    idx = m_eq ? 0 : 1;
                    emit();
                end
            end else emit();
        end
        #1;
        check_all();
    endtask

    int exp1[9] = '{3, 4, 5, 6, 6, 6, 5, 4, 3};

    initial begin
        reset = 1; start = 0; stop = 0; mode = 0; lo = '0; hi = '0; dwell = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 0;

        // one-shot 3..6 dwell 2, start held and config wiggled while busy
        cyc(1, 0, 0, 3, 6, 2);
        chk("tp1_count", 32'(count), 32'(exp1[0]));
        for (int i = 1; i < 9; i++) begin
            cyc(1, 0, 1, 0, 200, 5);
            chk("tp1_count", 32'(count), 32'(exp1[i]));
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("tp1_idle", 32'(busy), 32'(0));
        repeat (2) cyc(0, 1, 0, 0, 0, 0);

        // continuous 3..6, then stop
        cyc(1, 0, 1, 3, 6, 0);
        repeat (20) cyc(0, 0, 0, 1, 9, 3);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);

        // lo == hi one-shot, then continuous
        cyc(1, 0, 0, 5, 5, 1);
        repeat (5) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 7, 7, 0);
        repeat (6) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);

        // full range
        cyc(1, 0, 0, 0, 255, 0);
        repeat (514) cyc(0, 0, 0, 0, 0, 0);

        // rejected start, then a valid one clears err
        cyc(1, 0, 0, 9, 4, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 2, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0);

        // asynchronous reset in the middle of the down ramp
        cyc(1, 0, 0, 3, 6, 2);
        repeat (7) cyc(0, 0, 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #3 reset = 0;
        cyc(0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            int l, h, t;
            l = int'($urandom_range(0, 255));
            t = l + int'($urandom_range(0, 6));
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : (t > 255 ? 255 : t);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
                l, h, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
